systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/sa_pkg.sv | 32 +++
 rtl/sa_phase_cnt.sv | 41 ++++
 rtl/systolic_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic array controller.
//   sa_state_e    : controller FSM states
//   IDW           : width of one per-buffer load position field
//   CLEAR_LEN     : CLEAR phase length (2N-1) for the default array size
//   SHIFT_LEN     : SHIFT phase length (3N-2) for the default array size
//   clear_len()   : CLEAR phase length for any N
//   shift_len()   : SHIFT phase length for any N
package sa_pkg;

    localparam int IDW       = 3;
    localparam int N_DEF     = 4;
    localparam int CLEAR_LEN = 2 * N_DEF - 1;
    localparam int SHIFT_LEN = 3 * N_DEF - 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_OUTPUT = 3'd4,
        ST_DONE   = 3'd5
    } sa_state_e;

    function automatic int clear_len(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int shift_len(input int n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/sa_phase_cnt.sv
// Loadable down counter with zero flag; times the CLEAR, SHIFT and OUTPUT
// phases of the systolic controller.
//   clk, rst : clock, synchronous active-high reset
//   ld       : load ld_val (takes priority over counting)
//   ld_val   : value loaded (phase length minus one)
//   cnt      : current count, decrements by one per cycle, stops at zero
//   zero     : cnt == 0 (last cycle of the running phase)
module sa_phase_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = ld_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/systolic_ctrl.sv
// Controller sequencing one N x N matrix multiply on a systolic array:
// CLEAR the buffers, LOAD N operand beats, SHIFT them through, then
// collect N result rows during OUTPUT.
//   start / busy / done          : launch, activity flag, one-cycle completion pulse
//   mat_rd_en / mat_rd_idx       : operand fetch request for beat k (LOAD only)
//   mat_valid, a_in, b_in        : fetched column k of A / row k of B
//   load / shift / OutputSign    : mutually exclusive array enables
//   id_A / id_B, shift_in_A / _B : per-buffer load position and data
//   shift_out                    : array result row
//   res_valid / res_idx / res_row: captured result beat
//   stall_cnt                    : LOAD stall cycles, built only when the
//                                  macro SA_CTRL_PERF_EN is defined, else 0
module systolic_ctrl
    import sa_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DW      = 8,
    parameter int OUT_LAT = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 mat_rd_en,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] mat_rd_idx,
    input  logic                                 mat_valid,
    input  logic [N*DW-1:0]                      a_in,
    input  logic [N*DW-1:0]                      b_in,
    output logic                                 load,
    output logic                                 shift,
    output logic                                 OutputSign,
    output logic [N*IDW-1:0]                     id_A,
    output logic [N*IDW-1:0]                     id_B,
    output logic [N*DW-1:0]                      shift_in_A,
    output logic [N*DW-1:0]                      shift_in_B,
    input  logic [N*DW-1:0]                      shift_out,
    output logic                                 res_valid,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] res_idx,
    output logic [N*DW-1:0]                      res_row,
    output logic [15:0]                          stall_cnt
);

    localparam int KW    = (N > 1) ? $clog2(N) : 1;
    localparam int C_LEN = clear_len(N);
    localparam int S_LEN = shift_len(N);
    localparam int O_LEN = N + OUT_LAT;
    localparam int CW    = $clog2(C_LEN + S_LEN + O_LEN + 1);

    sa_state_e state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          start_acc;
    logic          cnt_ld;
    logic [CW-1:0] cnt_ld_val;
    logic [CW-1:0] cnt;
    logic          cnt_zero;
    logic [IDW-1:0] clr_id;

    sa_phase_cnt #(.W(CW)) u_phase_cnt (
        .clk    (clk),
        .rst    (rst),
        .ld     (cnt_ld),
        .ld_val (cnt_ld_val),
        .cnt    (cnt),
        .zero   (cnt_zero)
    );

    // Counter runs C_LEN-1 down to 0 in CLEAR, so elapsed cycles = C_LEN-1-cnt.
    assign clr_id = IDW'(CW'(C_LEN - 1) - cnt);
    assign busy   = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        start_acc  = 1'b0;
        cnt_ld     = 1'b0;
        cnt_ld_val = '0;
        done       = 1'b0;
        mat_rd_en  = 1'b0;
        mat_rd_idx = '0;
        load       = 1'b0;
        shift      = 1'b0;
        OutputSign = 1'b0;
        id_A       = '0;
        id_B       = '0;
        shift_in_A = '0;
        shift_in_B = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_d    = ST_CLEAR;
                    cnt_ld     = 1'b1;
                    cnt_ld_val = CW'(C_LEN - 1);
                end
            end
            ST_CLEAR: begin
                load = 1'b1;
                for (int i = 0; i < N; i++) begin
                    id_A[i*IDW +: IDW] = clr_id;
                    id_B[i*IDW +: IDW] = clr_id;
                end
                if (cnt_zero) begin
                    state_d = ST_LOAD;
                    k_d     = '0;
                end
            end
            ST_LOAD: begin
                mat_rd_en  = 1'b1;
                mat_rd_idx = k_q;
                // A stalled fetch holds k and keeps the array idle.
                if (mat_valid) begin
                    load       = 1'b1;
                    shift_in_A = a_in;
                    shift_in_B = b_in;
                    for (int i = 0; i < N; i++) begin
                        id_A[i*IDW +: IDW] = IDW'(k_q) + IDW'(i);
                        id_B[i*IDW +: IDW] = IDW'(k_q) + IDW'(i);
                    end
                    if (k_q == KW'(N - 1)) begin
                        state_d    = ST_SHIFT;
                        cnt_ld     = 1'b1;
                        cnt_ld_val = CW'(S_LEN - 1);
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                shift = 1'b1;
                if (cnt_zero) begin
                    state_d    = ST_OUTPUT;
                    cnt_ld     = 1'b1;
                    cnt_ld_val = CW'(O_LEN - 1);
                end
            end
            ST_OUTPUT: begin
                // First N of the N+OUT_LAT cycles request rows; the tail
                // only waits out the array's output latency.
                OutputSign = (cnt >= CW'(OUT_LAT));
                if (cnt_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result capture: OutputSign delay line, capture one cycle before res_valid.
    logic [OUT_LAT-1:0] os_pipe_q, os_pipe_d;
    logic [OUT_LAT:0]   os_tap;
    logic               res_cap;
    logic [N*DW-1:0]    res_row_q, res_row_d;
    logic [KW-1:0]      res_idx_q, res_idx_d;

    assign os_tap    = {os_pipe_q, OutputSign};
    assign res_cap   = os_tap[OUT_LAT-1];
    assign res_valid = os_tap[OUT_LAT];

    always_comb begin
        os_pipe_d = os_tap[OUT_LAT-1:0];
        res_row_d = res_cap ? shift_out : '0;
        res_idx_d = res_idx_q;
        if (start_acc) begin
            res_idx_d = '0;
        end else if (res_valid) begin
            res_idx_d = (res_idx_q == KW'(N - 1)) ? '0 : res_idx_q + 1'b1;
        end
    end

    assign res_row = res_row_q;
    assign res_idx = res_valid ? res_idx_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            os_pipe_q <= '0;
            res_row_q <= '0;
            res_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            os_pipe_q <= os_pipe_d;
            res_row_q <= res_row_d;
            res_idx_q <= res_idx_d;
        end
    end

`ifdef SA_CTRL_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_acc) begin
            stall_d = '0;
        end else if (state_q == ST_LOAD && !mat_valid && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl (N=4, DW=8, OUT_LAT=1).
// A small array model multiplies the loaded operands and drives shift_out;
// expected result rows are pushed when a run is launched and popped by the
// monitor on every res_valid beat.
module tb_systolic_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy, done;
    logic              mat_rd_en;
    logic [1:0]        mat_rd_idx;
    logic              mat_valid;
    logic [N*DW-1:0]   a_in, b_in;
    logic              load, shift, OutputSign;
    logic [N*3-1:0]    id_A, id_B;
    logic [N*DW-1:0]   shift_in_A, shift_in_B;
    logic [N*DW-1:0]   shift_out;
    logic              res_valid;
    logic [1:0]        res_idx;
    logic [N*DW-1:0]   res_row;
    logic [15:0]       stall_cnt;

    systolic_ctrl #(.N(N), .DW(DW), .OUT_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mat_rd_en  (mat_rd_en),
        .mat_rd_idx (mat_rd_idx),
        .mat_valid  (mat_valid),
        .a_in       (a_in),
        .b_in       (b_in),
        .load       (load),
        .shift      (shift),
        .OutputSign (OutputSign),
        .id_A       (id_A),
        .id_B       (id_B),
        .shift_in_A (shift_in_A),
        .shift_in_B (shift_in_B),
        .shift_out  (shift_out),
        .res_valid  (res_valid),
        .res_idx    (res_idx),
        .res_row    (res_row),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      idx;
        logic [N*DW-1:0] row;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t0 = 0;
    bit   done_flag = 0;
    int   done_rel = 0;
    int   beats = 0;
    bit   stall_mode = 0;

    // B = [1..16] row-major, A = identity, so C = B.
    logic [N*DW-1:0] b_rows [N];
    initial begin
        b_rows[0] = 32'h04030201;
        b_rows[1] = 32'h08070605;
        b_rows[2] = 32'h0C0B0A09;
        b_rows[3] = 32'h100F0E0D;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Operand source: column k of identity, row k of B.
    always_comb begin
        a_in = '0;
        b_in = '0;
        for (int i = 0; i < N; i++) begin
            a_in[i*DW +: DW] = (i == int'(mat_rd_idx)) ? 8'd1 : 8'd0;
            b_in[i*DW +: DW] = DW'(4 * int'(mat_rd_idx) + i + 1);
        end
    end

    // Array model: remember loaded operands, emit C rows on OutputSign.
    logic [N*DW-1:0] acol [N];
    logic [N*DW-1:0] brow [N];
    int              os_beat;

    always @(posedge clk) begin
        if (rst) begin
            os_beat <= 0;
        end else if (load && mat_rd_en) begin
            acol[mat_rd_idx] <= shift_in_A;
            brow[mat_rd_idx] <= shift_in_B;
            os_beat          <= 0;
        end else if (OutputSign) begin
            os_beat <= os_beat + 1;
        end
    end

    always_comb begin
        shift_out = '0;
        if (OutputSign && os_beat < N) begin
            for (int j = 0; j < N; j++) begin
                int acc;
                acc = 0;
                for (int k = 0; k < N; k++)
                    acc += int'(acol[k][os_beat*DW +: DW]) * int'(brow[k][j*DW +: DW]);
                shift_out[j*DW +: DW] = DW'(acc);
            end
        end
    end

    // Fetch-valid driver: optional stall on relative cycles 9 and 10.
    initial begin
        mat_valid = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            mat_valid = !(stall_mode && ((cyc - t0) == 9 || (cyc - t0) == 10));
        end
    end

    // Monitor: invariants every cycle, scoreboard pop on res_valid.
    always @(negedge clk) begin
        int bad_id;
        exp_t e;
        chk("onehot_enables", $onehot0({load, shift, OutputSign}), 1);
        bad_id = 0;
        for (int i = 0; i < N; i++)
            if (id_A[i*3 +: 3] > 3'd6 || id_B[i*3 +: 3] > 3'd6) bad_id = 1;
        chk("id_range", bad_id, 0);
        if (rst) beats = 0;
        if (res_valid) begin
            if (sb_q.size() == 0) begin
                chk("res_unexpected", res_row, 0);
                chk("res_unexpected_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("res_row", res_row, e.row);
                chk("res_idx", res_idx, e.idx);
            end
            beats++;
        end
        if (done) begin
            done_rel  = cyc - t0;
            done_flag = 1;
            chk("beats_per_run", beats, N);
            beats = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_rel(input int n);
        int lim;
        lim = 0;
        while ((cyc - t0) < n && lim < 200) begin
            @(negedge clk);
            lim++;
        end
        if ((cyc - t0) < n) chk("goto_timeout", cyc - t0, n);
    endtask

    task automatic push_run();
        exp_t e;
        for (int r = 0; r < N; r++) begin
            e.idx = 2'(r);
            e.row = b_rows[r];
            sb_q.push_back(e);
        end
    endtask

    task automatic launch();
        done_flag = 0;
        start     = 1'b1;
        t0        = cyc;
        step();
    endtask

    task automatic wait_done(input string nm, input int exp);
        int n;
        n = 0;
        while (!done_flag && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done_flag) chk({nm, "_timeout"}, 0, 1);
        else chk(nm, done_rel, exp);
        done_flag = 0;
    endtask

    initial begin
        int exp_stall;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_enables", {load, shift, OutputSign, done, mat_rd_en, res_valid}, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_ids", {id_A, id_B}, 0);
        step();
        rst = 1'b0;

        // start together with rst is ignored
        step();
        start = 1'b1;
        rst   = 1'b1;
        step();
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("start_with_rst_busy", busy, 0);
        step();
        @(negedge clk);
        chk("start_with_rst_busy2", busy, 0);

        // Nominal run
        step();
        push_run();
        launch();
        start = 1'b0;
        goto_rel(1);
        chk("clear0_load", load, 1);
        chk("clear0_id", {id_A, id_B}, 0);
        chk("clear0_data", {shift_in_A, shift_in_B}, 0);
        goto_rel(7);
        chk("clear6_id_B", id_B, 12'hDB6);
        goto_rel(8);
        chk("load0_rd_en", mat_rd_en, 1);
        chk("load0_id_A", id_A, 12'h688);
        chk("load0_data_B", shift_in_B, 32'h04030201);
        goto_rel(12);
        chk("shift_first", shift, 1);
        goto_rel(21);
        chk("shift_last", shift, 1);
        goto_rel(22);
        chk("osign_first", OutputSign, 1);
        goto_rel(26);
        chk("output_tail", {OutputSign, busy}, 2'b01);
        wait_done("done_nominal", 27);
        chk("stall_nominal", stall_cnt, 0);

        // Stalled run
        step();
        stall_mode = 1;
        push_run();
        launch();
        start = 1'b0;
        goto_rel(10);
        chk("stall_holds_idx", {load, mat_rd_en, mat_rd_idx}, 4'b0101);
        wait_done("done_stall", 29);
`ifdef SA_CTRL_PERF_EN
        exp_stall = 2;
`else
        exp_stall = 0;
`endif
        chk("stall_cnt", stall_cnt, exp_stall);
        stall_mode = 0;

        // Reset during SHIFT
        step();
        push_run();
        launch();
        start = 1'b0;
        goto_rel(15);
        chk("pre_rst_shift", shift, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_enables", {load, shift, OutputSign, done, mat_rd_en, res_valid}, 0);
        chk("post_rst_buses", {id_A, id_B, shift_in_A, shift_in_B, res_row}, 0);
        chk("post_rst_stall", stall_cnt, 0);
        step();
        push_run();
        launch();
        start = 1'b0;
        wait_done("done_after_rst", 27);

        // start held high across a whole run
        step();
        push_run();
        push_run();
        launch();
        wait_done("done_held_1", 27);
        goto_rel(28);
        chk("held_idle", busy, 0);
        goto_rel(29);
        chk("held_clear", {busy, load}, 2'b11);
        step();
        start = 1'b0;
        wait_done("done_held_2", 55);

        repeat (4) step();
        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1);
    end

endmodule
